layer_vector_assembler: RTL and testbench

- Collects the scalar neuron outputs produced one at a time by the adder-tree datapath.
- Packs them into a COUNT-wide operand vector for the next layer's multiply/reduce stage.
- This is the consumer side of the reduction: scalar in, COUNT-wide vector out.
- Double-buffered (two banks), so one layer's vector can be filled while the previous one is held for the downstream array.

---
 rtl/layer_vector_assembler.sv | 108 ++++++++++
 tb/tb_layer_vector_assembler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_vector_assembler.sv
// Double-banked scalar-to-vector assembler for the next layer's operands.
// Define LAYER_VECTOR_ASSEMBLER_RELU_EN to clamp negative elements on write.
module layer_vector_assembler #(
  parameter int DATA_WIDTH = 16,
  parameter int COUNT      = 128
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [COUNT-1:0][DATA_WIDTH-1:0]    out_vec,
  output logic [$clog2(COUNT+1)-1:0]          out_count
);

  localparam int IW = $clog2(COUNT);
  localparam int CW = $clog2(COUNT+1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_st_t;

  bank_st_t                         st_q [2];
  bank_st_t                         st_d [2];
  logic [COUNT-1:0][DATA_WIDTH-1:0] bank_q [2];
  logic [CW-1:0]                    cnt_q [2];
  logic                             fill_sel;
  logic                             rd_sel;
  logic [IW-1:0]                    wr_idx;
  logic                             wr_en;
  logic                             done;
  logic                             rel;
  logic [DATA_WIDTH-1:0]            wr_data;

  assign in_ready  = (st_q[fill_sel] != FULL);
  assign wr_en     = in_valid && in_ready;
  assign done      = wr_en &&
                     (in_last || wr_idx == IW'(COUNT-1));
  assign out_valid = (st_q[rd_sel] == FULL);
  assign rel       = out_valid && out_ready;
  assign out_vec   = bank_q[rd_sel];
  assign out_count = cnt_q[rd_sel];

`ifdef LAYER_VECTOR_ASSEMBLER_RELU_EN
  assign wr_data = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
  assign wr_data = in_data;
`endif

  // Per-bank lifecycle: fill target advances, read bank drains to EMPTY.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_d[b] = st_q[b];
      if (wr_en && fill_sel == 1'(b))
        st_d[b] = done ? FULL : FILLING;
      if (rel && rd_sel == 1'(b))
        st_d[b] = EMPTY;
    end
  end

  // Bank state, selectors and write index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]  <= EMPTY;
      st_q[1]  <= EMPTY;
      fill_sel <= 1'b0;
      rd_sel   <= 1'b0;
      wr_idx   <= '0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      if (done) begin
        wr_idx   <= '0;
        fill_sel <= ~fill_sel;
      end else if (wr_en) begin
        wr_idx <= wr_idx + IW'(1);
      end
      if (rel)
        rd_sel <= ~rd_sel;
    end
  end

  // Bank contents: write lane on accept, zero whole bank on release
  // so a short vector is always zero-padded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        bank_q[b] <= '0;
        cnt_q[b]  <= '0;
      end
    end else begin
      if (wr_en)
        bank_q[fill_sel][wr_idx] <= wr_data;
      if (done)
        cnt_q[fill_sel] <= CW'(wr_idx) + CW'(1);
      if (rel) begin
        bank_q[rd_sel] <= '0;
        cnt_q[rd_sel]  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_layer_vector_assembler.sv
// Randomized self-checking bench for layer_vector_assembler.
// Reference model: queue of completed vectors plus one partial vector.
module tb_layer_vector_assembler;

  localparam int DW = 16;
  localparam int N  = 128;
  localparam int CW = $clog2(N+1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic               out_ready = 1'b0;
  logic [DW-1:0]      in_data = '0;
  logic               in_ready;
  logic               out_valid;
  logic [N-1:0][DW-1:0] out_vec;
  logic [CW-1:0]      out_count;

  int n_cmp = 0;
  int n_bad = 0;
  int hs = 0;
  int stalls = 0;

  typedef logic [DW-1:0] vec_t [N];
  vec_t mq[$];
  int   mc[$];
  vec_t cur;
  int   cur_n = 0;
  logic acc;

  layer_vector_assembler #(
    .DATA_WIDTH(DW),
    .COUNT(N)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_vec(out_vec),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] stored(input logic [DW-1:0] d);
`ifdef LAYER_VECTOR_ASSEMBLER_RELU_EN
    return d[DW-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  task automatic model_clear();
    mq.delete();
    mc.delete();
    cur = '{default: '0};
    cur_n = 0;
  endtask

  // One clock: drive, compare against model, advance model at the edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d,
                       input logic l, input logic r,
                       output logic a);
    logic mr, mv;
    in_valid = v;
    in_data = d;
    in_last = l;
    out_ready = r;
    #1;
    mr = (mq.size() < 2);
    mv = (mq.size() != 0);
    chk("in_ready", 64'(in_ready), 64'(mr));
    chk("out_valid", 64'(out_valid), 64'(mv));
    if (mv) begin
      chk("out_count", 64'(out_count), 64'(mc[0]));
      for (int k = 0; k < N; k++)
        chk($sformatf("vec[%0d]", k), 64'(out_vec[k]), 64'(mq[0][k]));
    end
    a = v && mr;
    @(posedge clk);
    if (mv && r) begin
      mq.delete(0);
      mc.delete(0);
      hs++;
    end
    if (a) begin
      cur[cur_n] = stored(d);
      cur_n++;
      if (l || cur_n == N) begin
        mq.push_back(cur);
        mc.push_back(cur_n);
        cur = '{default: '0};
        cur_n = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    logic a;
    cycle(1'b0, '0, 1'b0, r, a);
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l,
                      input logic r);
    int t;
    logic a;
    t = 0;
    a = 1'b0;
    while (!a && t < 64) begin
      cycle(1'b1, d, l, r, a);
      if (!a) stalls++;
      t++;
    end
    chk("push_acc", 64'(a), 64'(1));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_count", 64'(out_count), 64'(0));
    for (int k = 0; k < N; k++)
      chk($sformatf("rst_vec[%0d]", k), 64'(out_vec[k]), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] e0;
    cur = '{default: '0};
    repeat (2) @(negedge clk);
    do_reset();

    // full vector, value = index, consumer stalled
    for (int i = 0; i < N; i++) push(DW'(i), 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // short vector 5,6,7
    push(DW'(5), 1'b0, 1'b0);
    push(DW'(6), 1'b0, 1'b0);
    push(DW'(7), 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // two full vectors, both banks full, one-cycle release pulse
    for (int i = 0; i < 2*N; i++) push(DW'($urandom), 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    chk("rdy_after_rel", 64'(in_ready), 64'(1));
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // continuous stream with consumer always ready
    hs = 0;
    stalls = 0;
    for (int i = 0; i < 3*N; i++) push(DW'($urandom), 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("handshakes", 64'(hs), 64'(3));
    chk("stalls", 64'(stalls), 64'(0));

    // reset mid-vector, then with one bank full
    for (int i = 0; i < 60; i++) push(DW'($urandom) | DW'(1), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < N+10; i++) push(DW'($urandom) | DW'(1), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) push(DW'($urandom), i == 3, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 3) != 0, DW'($urandom),
            $urandom_range(0, 40) == 0,
            $urandom_range(0, 2) == 0, acc);
    end

    // negative element handling
    do_reset();
    push(16'hFFF0, 1'b0, 1'b0);
    push(16'h0010, 1'b1, 1'b0);
    idle(1'b0);
`ifdef LAYER_VECTOR_ASSEMBLER_RELU_EN
    e0 = 16'h0000;
`else
    e0 = 16'hFFF0;
`endif
    chk("lane0_sign", 64'(out_vec[0]), 64'(e0));
    chk("lane1_pos", 64'(out_vec[1]), 64'(16'h0010));
    chk("cnt_two", 64'(out_count), 64'(2));
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
